// File: rtl/lane_issue_seq.sv
// Element sequencer for one vector lane: takes a whole vector instruction, issues it
// as per-element micro-ops under a credit limit, and collects per-element completions.
module lane_issue_seq #(
  parameter int unsigned VLEN_MAX        = 64,
  parameter int unsigned VL_W            = 7,
  parameter int unsigned OP_W            = 6,
  parameter int unsigned TAG_W           = 5,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_valid,
  output logic              inst_ready,
  input  logic [OP_W-1:0]   inst_op,
  input  logic [VL_W-1:0]   inst_vl,
  input  logic [TAG_W-1:0]  inst_tag,
  output logic              elem_valid,
  input  logic              elem_ready,
  output logic [OP_W-1:0]   elem_op,
  output logic [VL_W-2:0]   elem_idx,
  output logic              elem_last,
  output logic [TAG_W-1:0]  elem_tag,
  input  logic              res_valid,
  output logic              done_valid,
  output logic [TAG_W-1:0]  done_tag,
  output logic              busy,
  output logic              proto_err
);

  localparam int unsigned IDX_W = VL_W - 1;
  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [VL_W-1:0]  VLEN_MAX_L = VL_W'(VLEN_MAX);
  localparam logic [OUT_W-1:0] OUT_MAX    = OUT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [OP_W-1:0]    op_q, op_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [VL_W-1:0]    vl_q, vl_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [OUT_W-1:0]   out_q, out_d;
  logic               inst_ready_q, inst_ready_d;
  logic               elem_valid_q, elem_valid_d;
  logic               elem_last_q, elem_last_d;
  logic               done_valid_q, done_valid_d;
  logic [TAG_W-1:0]   done_tag_q, done_tag_d;
  logic               busy_q, busy_d;
  logic               proto_err_q, proto_err_d;

  logic               accept;
  logic               hs;
  logic               ret;
  logic [VL_W-1:0]    vl_clamp;

  // State and output registers; reset discards any in-flight instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      tag_q        <= '0;
      vl_q         <= '0;
      idx_q        <= '0;
      out_q        <= '0;
      inst_ready_q <= 1'b0;
      elem_valid_q <= 1'b0;
      elem_last_q  <= 1'b0;
      done_valid_q <= 1'b0;
      done_tag_q   <= '0;
      busy_q       <= 1'b0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      tag_q        <= tag_d;
      vl_q         <= vl_d;
      idx_q        <= idx_d;
      out_q        <= out_d;
      inst_ready_q <= inst_ready_d;
      elem_valid_q <= elem_valid_d;
      elem_last_q  <= elem_last_d;
      done_valid_q <= done_valid_d;
      done_tag_q   <= done_tag_d;
      busy_q       <= busy_d;
      proto_err_q  <= proto_err_d;
    end
  end

  // Next-state, credit accounting and next values of the registered outputs.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    tag_d        = tag_q;
    vl_d         = vl_q;
    idx_d        = idx_q;
    done_valid_d = 1'b0;
    done_tag_d   = done_tag_q;
    proto_err_d  = proto_err_q;

    accept   = inst_valid && inst_ready_q;
    hs       = elem_valid_q && elem_ready;
    vl_clamp = (inst_vl > VLEN_MAX_L) ? VLEN_MAX_L : inst_vl;

    // A return in the same cycle as an issue is always legal, even from zero.
    ret   = res_valid && ((out_q != '0) || hs);
    out_d = out_q + OUT_W'(hs) - OUT_W'(ret);
    if (res_valid && (out_q == '0) && !hs) begin
      proto_err_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d  = inst_op;
          tag_d = inst_tag;
          vl_d  = vl_clamp;
          idx_d = '0;
          if (vl_clamp == '0) begin
            done_valid_d = 1'b1;
            done_tag_d   = inst_tag;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (hs) begin
          idx_d = idx_q + IDX_W'(1);
          if (elem_last_q) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (out_d == '0) begin
          done_valid_d = 1'b1;
          done_tag_d   = tag_q;
          state_d      = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    elem_valid_d = (state_d == S_ISSUE) && (out_d < OUT_MAX);
    elem_last_d  = (state_d == S_ISSUE) && ({1'b0, idx_d} == (vl_d - VL_W'(1)));
    // Hold off dispatch during the completion cycle of a nonzero-length instruction.
    inst_ready_d = (state_d == S_IDLE) && (state_q != S_DRAIN);
    busy_d       = (state_d != S_IDLE);
  end

  assign inst_ready = inst_ready_q;
  assign elem_valid = elem_valid_q;
  assign elem_op    = op_q;
  assign elem_idx   = idx_q;
  assign elem_last  = elem_last_q;
  assign elem_tag   = tag_q;
  assign done_valid = done_valid_q;
  assign done_tag   = done_tag_q;
  assign busy       = busy_q;
  assign proto_err  = proto_err_q;

endmodule
